ov7670_sccb_target: RTL and testbench

OV7670_SCCB_TARGET -- requirements
Module: ov7670_sccb_target

---
 rtl/ov7670_sccb_target.sv | 187 ++++++++++++++++++
 tb/tb_ov7670_sccb_target.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_target.sv
// SCCB (I2C-like) register-access target: decodes ID/sub-address/data and drives open-drain ACKs and read bits.
// Latency: SYNC_STAGES+1 clk from a pin edge to its event; wr_en one clk after the last DATA bit is sampled.
// Backpressure: none; the master paces everything through sccb_scl, and the register-file strobe cannot be stalled.
module ov7670_sccb_target #(
    parameter logic [7:0] DEV_ADDR    = 8'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sccb_scl,
    inout  wire        sccb_sda,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, DEV, DEV_ACK, REG, REG_ACK, DATA, DATA_ACK, RD, RD_NA, WAIT_STOP
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic scl_s, sda_s, scl_q, sda_q;
    logic scl_rise, scl_fall, start, stop;

    logic [2:0] cnt, cnt_n, cnt_m1;
    logic [6:0] shreg, shreg_n;
    logic [7:0] rx_byte, tx, tx_n;
    logic [7:0] rd_addr_n, wr_addr_n, wr_data_n;
    logic       sda_oe, sda_oe_n, ack_on, ack_on_n, is_read, is_read_n;
    logic       wr_en_n, busy_n;

    assign sccb_sda = sda_oe ? 1'b0 : 1'bz;

    assign scl_s    = scl_sync[SYNC_STAGES-1];
    assign sda_s    = sda_sync[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_q;
    assign scl_fall = ~scl_s & scl_q;
    // scl must be high on both samples, so a bus event can never coincide with a bit edge
    assign start    = scl_s & scl_q & sda_q & ~sda_s;
    assign stop     = scl_s & scl_q & ~sda_q & sda_s;
    assign rx_byte  = {shreg, sda_s};
    assign cnt_m1   = cnt - 3'd1;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        shreg_n   = shreg;
        tx_n      = tx;
        rd_addr_n = rd_addr;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        sda_oe_n  = sda_oe;
        ack_on_n  = ack_on;
        is_read_n = is_read;
        busy_n    = busy;
        wr_en_n   = 1'b0;
        if (start) begin
            state_n  = DEV;
            cnt_n    = 3'd7;
            sda_oe_n = 1'b0;
            ack_on_n = 1'b0;
        end else if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
            ack_on_n = 1'b0;
            busy_n   = 1'b0;
        end else begin
            case (state)
                DEV, REG, DATA: begin
                    if (scl_rise) begin
                        shreg_n = shreg[5:0] == shreg[5:0] ? {shreg[5:0], sda_s} : shreg;
                        cnt_n   = cnt_m1;
                        if (cnt == 3'd0) begin
                            if (state == DEV) begin
                                if (rx_byte == DEV_ADDR) begin
                                    state_n   = DEV_ACK;
                                    is_read_n = 1'b0;
                                    busy_n    = 1'b1;
                                end else if (rx_byte == (DEV_ADDR | 8'h01)) begin
                                    state_n   = DEV_ACK;
                                    is_read_n = 1'b1;
                                    busy_n    = 1'b1;
                                end else begin
                                    state_n = WAIT_STOP;
                                    busy_n  = 1'b0;
                                end
                            end else if (state == REG) begin
                                rd_addr_n = rx_byte;
                                state_n   = REG_ACK;
                            end else begin
                                wr_en_n   = 1'b1;
                                wr_addr_n = rd_addr;
                                wr_data_n = rx_byte;
                                state_n   = DATA_ACK;
                            end
                        end
                    end
                end
                DEV_ACK, REG_ACK, DATA_ACK: begin
                    // first fall opens the ACK slot, second fall closes it
                    if (scl_fall) begin
                        if (!ack_on) begin
                            ack_on_n = 1'b1;
                            sda_oe_n = 1'b1;
                            if (state == DEV_ACK) tx_n = rd_data;
                        end else begin
                            ack_on_n = 1'b0;
                            sda_oe_n = 1'b0;
                            cnt_n    = 3'd7;
                            if (state == DEV_ACK) begin
                                if (is_read) begin
                                    state_n  = RD;
                                    sda_oe_n = ~tx[7];
                                end else begin
                                    state_n = REG;
                                end
                            end else if (state == REG_ACK) begin
                                state_n = DATA;
                            end else begin
                                state_n = WAIT_STOP;
                            end
                        end
                    end
                end
                RD: begin
                    if (scl_fall) begin
                        if (cnt == 3'd0) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_NA;
                        end else begin
                            cnt_n    = cnt_m1;
                            sda_oe_n = ~tx[cnt_m1];
                        end
                    end
                end
                RD_NA: begin
                    if (scl_fall) state_n = WAIT_STOP;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            state    <= IDLE;
            cnt      <= 3'd7;
            shreg    <= '0;
            tx       <= '0;
            rd_addr  <= '0;
            wr_addr  <= '0;
            wr_data  <= '0;
            sda_oe   <= 1'b0;
            ack_on   <= 1'b0;
            is_read  <= 1'b0;
            busy     <= 1'b0;
            wr_en    <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], sccb_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sccb_sda};
            scl_q    <= scl_s;
            sda_q    <= sda_s;
            state    <= state_n;
            cnt      <= cnt_n;
            shreg    <= shreg_n;
            tx       <= tx_n;
            rd_addr  <= rd_addr_n;
            wr_addr  <= wr_addr_n;
            wr_data  <= wr_data_n;
            sda_oe   <= sda_oe_n;
            ack_on   <= ack_on_n;
            is_read  <= is_read_n;
            busy     <= busy_n;
            wr_en    <= wr_en_n;
        end
    end

endmodule

// File: tb/tb_ov7670_sccb_target.sv
// Bench for ov7670_sccb_target: a bit-banged SCCB master plus a register-file model predicting ACKs, writes and read data.
module tb_ov7670_sccb_target;
    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       scl_m;
    logic       sda_low_m;
    wire        sda_bus;
    logic       wr_en;
    logic [7:0] wr_addr, wr_data, rd_addr, rd_data;
    logic       busy;

    logic       rd_ovr;
    logic [7:0] rd_ovr_val;
    logic [7:0] ext_mem [256];
    logic [7:0] mem_model [256];
    logic [7:0] ptr_model;
    logic [7:0] last_addr, last_data;
    int         wr_cnt = 0;
    int         tests = 0;
    int         fails = 0;

    pullup (sda_bus);
    assign sda_bus = sda_low_m ? 1'b0 : 1'bz;
    always_comb rd_data = rd_ovr ? rd_ovr_val : ext_mem[rd_addr];

    always #5 clk = ~clk;

    ov7670_sccb_target #(.DEV_ADDR(8'h42), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .sccb_scl(scl_m), .sccb_sda(sda_bus),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy)
    );

    // external register file: reacts to committed writes
    initial begin
        for (int i = 0; i < 256; i++) ext_mem[i] = 8'(i) ^ 8'h5A;
        forever begin
            @(negedge clk);
            if (wr_en === 1'b1) begin
                wr_cnt++;
                last_addr = wr_addr;
                last_data = wr_data;
                ext_mem[wr_addr] = wr_data;
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic s);
        sda_low_m = ~b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); s = sda_bus;
        wait_clk(Q); scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_start();
        scl_m = 1'b0; sda_low_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_low_m = 1'b1;
        wait_clk(Q); scl_m = 1'b0;
        wait_clk(Q);
    endtask

    task automatic bus_stop();
        scl_m = 1'b0; sda_low_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_low_m = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            v[i] = s;
        end
        bus_bit(1'b1, s);
    endtask

    task automatic test_reset();
        tests++; if (wr_en !== 1'b0) begin fails++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        tests++; if (wr_addr !== 8'h00) begin fails++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        tests++; if (wr_data !== 8'h00) begin fails++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        tests++; if (rd_addr !== 8'h00) begin fails++; $display("FAIL reset_rd_addr got %h want 00", rd_addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL reset_sda got %b want 1", sda_bus); end
    endtask

    task automatic test_write3();
        logic a0, a1, a2;
        int w0 = wr_cnt;
        bus_start();
        write_byte(8'h42, a0);
        write_byte(8'h12, a1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL w3_busy got %b want 1", busy); end
        write_byte(8'h80, a2);
        bus_stop();
        ptr_model = 8'h12; mem_model[8'h12] = 8'h80;
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL w3_acks got %b want 111", {a0, a1, a2}); end
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL w3_wr_count got %0d want 1", wr_cnt - w0); end
        tests++; if (last_addr !== 8'h12 || last_data !== 8'h80) begin
            fails++; $display("FAIL w3_write got %h/%h want 12/80", last_addr, last_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL w3_busy_after_stop got %b want 0", busy); end
    endtask

    task automatic test_read();
        logic a0, a1, a2;
        logic [7:0] v;
        int w0 = wr_cnt;
        bus_start(); write_byte(8'h42, a0); write_byte(8'h0A, a1); bus_stop();
        rd_ovr = 1'b1; rd_ovr_val = 8'h76;
        bus_start(); write_byte(8'h43, a2); read_byte(v); bus_stop();
        rd_ovr = 1'b0;
        ptr_model = 8'h0A;
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL rd_acks got %b want 111", {a0, a1, a2}); end
        tests++; if (rd_addr !== 8'h0A) begin fails++; $display("FAIL rd_addr got %h want 0a", rd_addr); end
        tests++; if (v !== 8'h76) begin fails++; $display("FAIL rd_bits got %b want 01110110", v); end
        tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL rd_no_write got %0d want %0d", wr_cnt, w0); end
    endtask

    task automatic test_bad_id();
        logic a0, a1, a2, b;
        int w0 = wr_cnt;
        bus_start(); write_byte(8'h60, a0);
        b = busy;
        write_byte(8'h12, a1); write_byte(8'h80, a2); bus_stop();
        tests++; if ({a0, a1, a2} !== 3'b000) begin fails++; $display("FAIL bad_id_acks got %b want 000", {a0, a1, a2}); end
        tests++; if (b !== 1'b0) begin fails++; $display("FAIL bad_id_busy got %b want 0", b); end
        tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL bad_id_write got %0d want %0d", wr_cnt, w0); end
        tests++; if (rd_addr !== ptr_model) begin fails++; $display("FAIL bad_id_rd_addr got %h want %h", rd_addr, ptr_model); end
    endtask

    task automatic test_abort_restart();
        logic a0, a1, a2, s;
        logic [7:0] part;
        int w0 = wr_cnt;
        part = 8'hA5;
        bus_start(); write_byte(8'h42, a0); write_byte(8'h12, a1);
        for (int i = 7; i >= 4; i--) bus_bit(part[i], s);
        bus_stop();
        ptr_model = 8'h12;
        tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL partial_write got %0d want %0d", wr_cnt, w0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL partial_busy got %b want 0", busy); end
        tests++; if (rd_addr !== 8'h12) begin fails++; $display("FAIL partial_rd_addr got %h want 12", rd_addr); end
        bus_start(); write_byte(8'h42, a0);
        for (int i = 7; i >= 5; i--) bus_bit(part[i], s);
        bus_start();
        write_byte(8'h42, a0); write_byte(8'h3A, a1); write_byte(8'h0F, a2); bus_stop();
        ptr_model = 8'h3A; mem_model[8'h3A] = 8'h0F;
        tests++; if ({a0, a1, a2} !== 3'b111) begin fails++; $display("FAIL rstart_acks got %b want 111", {a0, a1, a2}); end
        tests++; if (wr_cnt - w0 !== 1 || last_addr !== 8'h3A || last_data !== 8'h0F) begin
            fails++; $display("FAIL rstart_write got %0d %h/%h want 1 3a/0f", wr_cnt - w0, last_addr, last_data); end
    endtask

    task automatic test_reset_in_ack();
        logic a0, a1, s;
        logic [7:0] d;
        int w0 = wr_cnt;
        d = 8'h55;
        bus_start(); write_byte(8'h42, a0); write_byte(8'h12, a1);
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        sda_low_m = 1'b0;
        wait_clk(2);
        mem_model[8'h12] = 8'h55;
        tests++; if (sda_bus !== 1'b0) begin fails++; $display("FAIL ack_drive got %b want 0", sda_bus); end
        reset = 1'b1;
        wait_clk(1);
        tests++; if (sda_bus !== 1'b1) begin fails++; $display("FAIL rst_sda got %b want 1", sda_bus); end
        tests++; if ({wr_en, busy, wr_addr, wr_data, rd_addr} !== 26'd0) begin
            fails++; $display("FAIL rst_outputs got %b/%b/%h/%h/%h want all 0", wr_en, busy, wr_addr, wr_data, rd_addr); end
        wait_clk(1);
        reset = 1'b0;
        ptr_model = 8'h00;
        tests++; if (wr_cnt - w0 !== 1) begin fails++; $display("FAIL rst_wr_count got %0d want 1", wr_cnt - w0); end
        scl_m = 1'b1; wait_clk(Q);
        bus_stop();
        w0 = wr_cnt;
        bus_start(); write_byte(8'h42, a0); write_byte(8'h44, a1); write_byte(8'h99, s); bus_stop();
        ptr_model = 8'h44; mem_model[8'h44] = 8'h99;
        tests++; if ({a0, a1, s} !== 3'b111 || wr_cnt - w0 !== 1 || last_addr !== 8'h44 || last_data !== 8'h99) begin
            fails++; $display("FAIL post_rst_write got acks %b cnt %0d %h/%h want 111 1 44/99", {a0, a1, s}, wr_cnt - w0, last_addr, last_data); end
    endtask

    task automatic test_glitch();
        int w0 = wr_cnt;
        logic b_any = 1'b0;
        scl_m = 1'b1; sda_low_m = 1'b0;
        wait_clk(Q);
        for (int i = 0; i < 6; i++) begin
            sda_low_m = ~sda_low_m;
            wait_clk(Q);
            b_any = b_any | busy;
        end
        sda_low_m = 1'b0;
        wait_clk(2 * Q);
        tests++; if (wr_cnt !== w0) begin fails++; $display("FAIL glitch_write got %0d want %0d", wr_cnt, w0); end
        tests++; if (b_any !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b want 0", b_any); end
        tests++; if (rd_addr !== ptr_model) begin fails++; $display("FAIL glitch_rd_addr got %h want %h", rd_addr, ptr_model); end
    endtask

    task automatic test_random();
        logic a0, a1, a2;
        logic [7:0] r, d, id, v;
        int kind, w0;
        for (int n = 0; n < 14; n++) begin
            kind = $urandom_range(0, 3);
            r = 8'($urandom); d = 8'($urandom);
            w0 = wr_cnt;
            case (kind)
                0: begin
                    bus_start(); write_byte(8'h42, a0); write_byte(r, a1); write_byte(d, a2); bus_stop();
                    ptr_model = r; mem_model[r] = d;
                    tests++; if ({a0, a1, a2} !== 3'b111 || wr_cnt - w0 !== 1 || last_addr !== r || last_data !== d) begin
                        fails++; $display("FAIL rnd_write got acks %b cnt %0d %h/%h want 111 1 %h/%h", {a0, a1, a2}, wr_cnt - w0, last_addr, last_data, r, d); end
                end
                1: begin
                    bus_start(); write_byte(8'h42, a0); write_byte(r, a1); bus_stop();
                    ptr_model = r;
                    tests++; if ({a0, a1} !== 2'b11 || wr_cnt !== w0) begin
                        fails++; $display("FAIL rnd_setaddr got acks %b cnt %0d want 11 0", {a0, a1}, wr_cnt - w0); end
                end
                2: begin
                    bus_start(); write_byte(8'h43, a0); read_byte(v); bus_stop();
                    tests++; if (a0 !== 1'b1 || v !== mem_model[ptr_model] || wr_cnt !== w0) begin
                        fails++; $display("FAIL rnd_read got ack %b data %h want 1 %h", a0, v, mem_model[ptr_model]); end
                end
                default: begin
                    id = 8'($urandom);
                    if (id[7:1] == 7'h21) id = id ^ 8'h80;
                    bus_start(); write_byte(id, a0); write_byte(r, a1); write_byte(d, a2); bus_stop();
                    tests++; if ({a0, a1, a2} !== 3'b000 || wr_cnt !== w0) begin
                        fails++; $display("FAIL rnd_bad_id %h got acks %b cnt %0d want 000 0", id, {a0, a1, a2}, wr_cnt - w0); end
                end
            endcase
            tests++; if (rd_addr !== ptr_model) begin fails++; $display("FAIL rnd_rd_addr got %h want %h", rd_addr, ptr_model); end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
        ptr_model = 8'h00;
        rd_ovr = 1'b0; rd_ovr_val = 8'h00;
        reset = 1'b1; scl_m = 1'b1; sda_low_m = 1'b0;
        wait_clk(5);
        reset = 1'b0;
        wait_clk(3);
        test_reset();
        test_write3();
        test_read();
        test_bad_id();
        test_abort_restart();
        test_reset_in_ack();
        test_glitch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
